mem_block_mover: RTL and testbench

Bus-master engine that drives the data memory's single port (DataAddress, ReadMem, WriteMem, DataIn, DataOut) to copy or fill a block of bytes without CPU involvement. It sits between the CPU's control logic and the data memory. The CPU side muxes the memory port to this block while Busy is high. The memory returns DataOut combinationally and commits writes on the rising clock edge; this block is built around that timing.

---
 rtl/mem_block_mover.sv | 132 +++++++++++++
 tb/tb_mem_block_mover.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_block_mover.sv
// Bus-master block mover: copies or fills a run of bytes in the single-port data memory.
// Memory strobes are decoded from registered state, so they stay glitch-free through each cycle.
module mem_block_mover (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       Start,
  input  logic       Mode,
  input  logic [7:0] SrcAddr,
  input  logic [7:0] DstAddr,
  input  logic [7:0] Length,
  input  logic [7:0] FillByte,
  input  logic       Abort,
  input  logic [7:0] DataOut,
  output logic [7:0] DataAddress,
  output logic       ReadMem,
  output logic       WriteMem,
  output logic [7:0] DataIn,
  output logic       Busy,
  output logic       Done,
  output logic       Aborted,
  output logic [7:0] BytesDone,
  output logic [7:0] Checksum
);

  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

  state_t     state_q;
  logic       mode_q;
  logic [7:0] src_q;
  logic [7:0] dst_q;
  logic [7:0] len_q;
  logic [7:0] fill_q;
  logic [7:0] hold_q;
  logic [7:0] bytes_q;
  logic [7:0] sum_q;
  logic       aborted_q;

  logic [7:0] bytes_d;
  logic [7:0] wrData;

  assign bytes_d = bytes_q + 8'd1;
  assign wrData  = mode_q ? fill_q : hold_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      mode_q    <= 1'b0;
      src_q     <= 8'd0;
      dst_q     <= 8'd0;
      len_q     <= 8'd0;
      fill_q    <= 8'd0;
      hold_q    <= 8'd0;
      bytes_q   <= 8'd0;
      sum_q     <= 8'd0;
      aborted_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (Start) begin
            mode_q    <= Mode;
            src_q     <= SrcAddr;
            dst_q     <= DstAddr;
            len_q     <= Length;
            fill_q    <= FillByte;
            bytes_q   <= 8'd0;
            sum_q     <= 8'd0;
            aborted_q <= 1'b0;
            if (Length == 8'd0)
              state_q <= DONE;
            else if (Mode)
              state_q <= WR;
            else
              state_q <= RD;
          end
        end
        RD: begin
          if (Abort) begin
            aborted_q <= 1'b1;
            state_q   <= DONE;
          end else begin
            hold_q  <= DataOut;
            state_q <= WR;
          end
        end
        WR: begin
          // The write in flight always commits, even when Abort arrives with it.
          src_q   <= src_q + 8'd1;
          dst_q   <= dst_q + 8'd1;
          bytes_q <= bytes_d;
          sum_q   <= sum_q + wrData;
          if (Abort) begin
            aborted_q <= 1'b1;
            state_q   <= DONE;
          end else if (bytes_d == len_q)
            state_q <= DONE;
          else if (mode_q)
            state_q <= WR;
          else
            state_q <= RD;
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    DataAddress = 8'd0;
    ReadMem     = 1'b0;
    WriteMem    = 1'b0;
    DataIn      = 8'd0;
    case (state_q)
      RD: begin
        DataAddress = src_q;
        ReadMem     = 1'b1;
      end
      WR: begin
        DataAddress = dst_q;
        WriteMem    = 1'b1;
        DataIn      = wrData;
      end
      default: ;
    endcase
  end

  assign Busy      = (state_q != IDLE);
  assign Done      = (state_q == DONE);
  assign Aborted   = aborted_q;
  assign BytesDone = bytes_q;
  assign Checksum  = sum_q;

endmodule

// File: tb/tb_mem_block_mover.sv
// Directed bench for mem_block_mover with a behavioural single-port memory.
// Expected values are hand-computed from the block's cycle timing.
module tb_mem_block_mover;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       Start;
  logic       Mode;
  logic [7:0] SrcAddr;
  logic [7:0] DstAddr;
  logic [7:0] Length;
  logic [7:0] FillByte;
  logic       Abort;
  logic [7:0] DataOut;
  logic [7:0] DataAddress;
  logic       ReadMem;
  logic       WriteMem;
  logic [7:0] DataIn;
  logic       Busy;
  logic       Done;
  logic       Aborted;
  logic [7:0] BytesDone;
  logic [7:0] Checksum;

  logic [7:0] mem [256];
  int         writeCount = 0;
  int         passCount  = 0;
  int         totalCount = 0;
  int         cyc;
  int         w0;

  mem_block_mover dut (
    .clk(clk), .reset_n(reset_n), .Start(Start), .Mode(Mode),
    .SrcAddr(SrcAddr), .DstAddr(DstAddr), .Length(Length), .FillByte(FillByte),
    .Abort(Abort), .DataOut(DataOut), .DataAddress(DataAddress),
    .ReadMem(ReadMem), .WriteMem(WriteMem), .DataIn(DataIn), .Busy(Busy),
    .Done(Done), .Aborted(Aborted), .BytesDone(BytesDone), .Checksum(Checksum)
  );

  always #5 clk = ~clk;

  // Combinational read, write committed on the rising edge.
  assign DataOut = mem[DataAddress];
  always @(posedge clk) begin
    if (WriteMem) begin
      mem[DataAddress] <= DataIn;
      writeCount <= writeCount + 1;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    totalCount++;
    assert (obs === exp) passCount++;
    else $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_addr"}, {24'd0, DataAddress}, 32'd0);
    checkOutput({tag, "_rd"}, {31'd0, ReadMem}, 32'd0);
    checkOutput({tag, "_wr"}, {31'd0, WriteMem}, 32'd0);
    checkOutput({tag, "_din"}, {24'd0, DataIn}, 32'd0);
    checkOutput({tag, "_busy"}, {31'd0, Busy}, 32'd0);
    checkOutput({tag, "_done"}, {31'd0, Done}, 32'd0);
    checkOutput({tag, "_abt"}, {31'd0, Aborted}, 32'd0);
    checkOutput({tag, "_bytes"}, {24'd0, BytesDone}, 32'd0);
    checkOutput({tag, "_sum"}, {24'd0, Checksum}, 32'd0);
  endtask

  // Drives Start for exactly one rising edge (edge 0); returns just inside cycle 1.
  task automatic applyStimulus(input logic m, input logic [7:0] src, input logic [7:0] dst,
                               input logic [7:0] len, input logic [7:0] fb);
    @(negedge clk);
    Start = 1'b1; Mode = m; SrcAddr = src; DstAddr = dst; Length = len; FillByte = fb;
    @(posedge clk);
    #1 Start = 1'b0;
  endtask

  // Called just inside cycle startCyc; returns mid-cycle of the Done pulse, or -1 on timeout.
  task automatic waitDone(input int startCyc, output int doneCyc);
    doneCyc = -1;
    for (int c = startCyc; c < startCyc + 100; c++) begin
      @(negedge clk);
      if (Done) begin
        doneCyc = c;
        break;
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'd0;
    reset_n = 1'b0; Start = 1'b0; Mode = 1'b0; SrcAddr = 8'd0; DstAddr = 8'd0;
    Length = 8'd0; FillByte = 8'd0; Abort = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkAllZero("reset");
    reset_n = 1'b1;

    // Copy 4 bytes 0x20 -> 0x40
    mem[8'h20] = 8'd5; mem[8'h21] = 8'd6; mem[8'h22] = 8'd7; mem[8'h23] = 8'd8;
    w0 = writeCount;
    applyStimulus(1'b0, 8'h20, 8'h40, 8'd4, 8'h00);
    @(negedge clk);
    checkOutput("copy_c1_rd", {31'd0, ReadMem}, 32'd1);
    checkOutput("copy_c1_addr", {24'd0, DataAddress}, 32'h20);
    checkOutput("copy_c1_busy", {31'd0, Busy}, 32'd1);
    @(posedge clk); #1;
    waitDone(2, cyc);
    checkOutput("copy_done_cyc", cyc, 32'd9);
    checkOutput("copy_writes", writeCount - w0, 32'd4);
    checkOutput("copy_bytes", {24'd0, BytesDone}, 32'd4);
    checkOutput("copy_sum", {24'd0, Checksum}, 32'd26);
    checkOutput("copy_abt", {31'd0, Aborted}, 32'd0);
    checkOutput("copy_mem", {mem[8'h40], mem[8'h41], mem[8'h42], mem[8'h43]}, 32'h05060708);
    @(negedge clk);
    checkOutput("copy_idle_busy", {31'd0, Busy}, 32'd0);

    // Fill 3 bytes across the 0xFF -> 0x00 wrap
    applyStimulus(1'b1, 8'h00, 8'hFE, 8'd3, 8'hA5);
    @(negedge clk);
    checkOutput("fill_c1_wr", {31'd0, WriteMem}, 32'd1);
    checkOutput("fill_c1_din", {24'd0, DataIn}, 32'hA5);
    checkOutput("fill_c1_addr", {24'd0, DataAddress}, 32'hFE);
    @(posedge clk); #1;
    waitDone(2, cyc);
    checkOutput("fill_done_cyc", cyc, 32'd4);
    checkOutput("fill_sum", {24'd0, Checksum}, 32'hEF);
    checkOutput("fill_bytes", {24'd0, BytesDone}, 32'd3);
    checkOutput("fill_mem", {8'd0, mem[8'hFE], mem[8'hFF], mem[8'h00]}, 32'h00A5A5A5);

    // Overlapping forward copy replicates mem[0x10]
    mem[8'h10] = 8'd9; mem[8'h14] = 8'h33;
    applyStimulus(1'b0, 8'h10, 8'h11, 8'd3, 8'h00);
    waitDone(1, cyc);
    checkOutput("ovl_done_cyc", cyc, 32'd7);
    checkOutput("ovl_mem", {mem[8'h11], mem[8'h12], mem[8'h13], mem[8'h14]}, 32'h09090933);
    checkOutput("ovl_sum", {24'd0, Checksum}, 32'd27);

    // Abort in the third RD cycle of an 8-byte copy
    for (int i = 0; i < 8; i++) mem[8'h60 + i[7:0]] = 8'(i + 1);
    w0 = writeCount;
    applyStimulus(1'b0, 8'h60, 8'h80, 8'd8, 8'h00);
    repeat (5) @(negedge clk);
    checkOutput("abt_c5_rd", {31'd0, ReadMem}, 32'd1);
    checkOutput("abt_c5_addr", {24'd0, DataAddress}, 32'h62);
    Abort = 1'b1;
    @(posedge clk);
    #1 Abort = 1'b0;
    @(negedge clk);
    checkOutput("abt_done", {31'd0, Done}, 32'd1);
    checkOutput("abt_flag", {31'd0, Aborted}, 32'd1);
    checkOutput("abt_bytes", {24'd0, BytesDone}, 32'd2);
    checkOutput("abt_sum", {24'd0, Checksum}, 32'd3);
    checkOutput("abt_writes", writeCount - w0, 32'd2);
    checkOutput("abt_mem", {8'd0, mem[8'h80], mem[8'h81], mem[8'h82]}, 32'h00010200);
    @(negedge clk);
    checkOutput("abt_hold", {31'd0, Aborted}, 32'd1);

    // Length 0: Done in cycle 1, no strobes, and Aborted is cleared
    w0 = writeCount;
    applyStimulus(1'b0, 8'h00, 8'h50, 8'd0, 8'h00);
    checkOutput("len0_abt_clr", {31'd0, Aborted}, 32'd0);
    waitDone(1, cyc);
    checkOutput("len0_done_cyc", cyc, 32'd1);
    checkOutput("len0_rd", {31'd0, ReadMem}, 32'd0);
    checkOutput("len0_writes", writeCount - w0, 32'd0);

    // Start pulsed mid-transfer is ignored
    mem[8'hA0] = 8'h77;
    w0 = writeCount;
    applyStimulus(1'b1, 8'h00, 8'h90, 8'd4, 8'h11);
    @(negedge clk);
    Start = 1'b1; Mode = 1'b0; DstAddr = 8'hA0; Length = 8'd1; FillByte = 8'hEE;
    @(posedge clk);
    #1 Start = 1'b0;
    waitDone(2, cyc);
    checkOutput("busy_done_cyc", cyc, 32'd5);
    checkOutput("busy_writes", writeCount - w0, 32'd4);
    checkOutput("busy_sum", {24'd0, Checksum}, 32'h44);
    checkOutput("busy_mem", {mem[8'h90], mem[8'h91], mem[8'h92], mem[8'h93]}, 32'h11111111);
    checkOutput("busy_untouched", {24'd0, mem[8'hA0]}, 32'h77);

    // Reset during a WR cycle of a fill
    applyStimulus(1'b1, 8'h00, 8'hB0, 8'd6, 8'h22);
    @(negedge clk);
    @(negedge clk);
    checkOutput("rst_c2_wr", {31'd0, WriteMem}, 32'd1);
    reset_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checkAllZero("rst_mid");
    checkOutput("rst_mem", {8'd0, mem[8'hB0], mem[8'hB1], mem[8'hB2]}, 32'h00222200);
    reset_n = 1'b1;
    applyStimulus(1'b0, 8'h20, 8'hC0, 8'd2, 8'h00);
    waitDone(1, cyc);
    checkOutput("rst_after_cyc", cyc, 32'd5);
    checkOutput("rst_after_mem", {16'd0, mem[8'hC0], mem[8'hC1]}, 32'h0506);

    $display("%0d/%0d checks passed", passCount, totalCount);
    $finish;
  end

endmodule
